guarded_counter_checker: RTL and testbench

Receive-side monitor for a guarded unsigned counter stream: samples an n-bit count plus its even-/odd-position popcount guard fields, checks both the guard fields and the +1 sequence, and reports lock, per-sample error pulses, a sticky fault and a saturating error count. It sits wherever a guarded counter crosses a radiation- or noise-exposed boundary, at the consumer end of the counter's output bus.

---
 rtl/guarded_counter_checker.sv | 156 +++++++++++++++
 tb/tb_guarded_counter_checker.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/guarded_counter_checker.sv
// guarded_counter_checker: receive-side monitor for a guarded counter stream.
// Checks the even/odd popcount guard fields and the +1 sequence of every
// valid sample, tracks lock, and reports error pulses, a sticky fault and a
// saturating error count. All outputs are registered (one-cycle latency).
//
// Handshake: in_valid qualifies a sample on the rising edge of clk; there is
// no backpressure, so every cycle with in_valid=1 is consumed at full rate.
module guarded_counter_checker #(
  parameter int width      = 8,
  parameter int guard_bits = 4,
  parameter int lock_count = 4,
  parameter int err_width  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [width-1:0]      in_value,
  input  logic [guard_bits-1:0] in_even,
  input  logic [guard_bits-1:0] in_odd,
  input  logic                  clear_err,
  output logic                  locked,
  output logic                  fault,
  output logic                  guard_err,
  output logic                  seq_err,
  output logic [err_width-1:0]  err_count,
  output logic [1:0]            state
);

  localparam int SW = $clog2(lock_count + 1);
  localparam logic [SW-1:0] LOCK_N = SW'(lock_count);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t                r_state;
  logic [SW-1:0]         r_streak;
  logic [width-1:0]      r_prev;
  logic                  r_locked;
  logic                  r_fault;
  logic                  r_guard_err;
  logic                  r_seq_err;
  logic [err_width-1:0]  r_err_count;

  logic [guard_bits-1:0] w_exp_even;
  logic [guard_bits-1:0] w_exp_odd;
  logic                  w_guard_bad;
  logic                  w_seq_bad;
  logic                  w_bad;
  logic [SW-1:0]         w_streak_inc;
  state_t                w_state_nxt;
  logic [SW-1:0]         w_streak_nxt;
  logic [width-1:0]      w_prev_nxt;
  logic                  w_lock_lost;
  logic                  w_fault_nxt;
  logic [err_width-1:0]  w_err_base;
  logic [err_width-1:0]  w_err_nxt;

  // Popcount of even- and odd-indexed bits; accumulators wrap mod 2^guard_bits.
  always_comb begin
    w_exp_even = '0;
    w_exp_odd  = '0;
    for (int i = 0; i < width; i++) begin
      if ((i % 2) == 0)
        w_exp_even = w_exp_even + {{(guard_bits-1){1'b0}}, in_value[i]};
      else
        w_exp_odd  = w_exp_odd + {{(guard_bits-1){1'b0}}, in_value[i]};
    end
  end

  // Error classification. A sample whose guards are wrong carries an
  // untrustworthy value, so it is not also judged against the sequence.
  assign w_guard_bad = (in_even != w_exp_even) || (in_odd != w_exp_odd);
  assign w_seq_bad   = (r_state != ST_IDLE) && !w_guard_bad &&
                       (in_value != r_prev + width'(1));
  assign w_bad       = w_guard_bad || w_seq_bad;
  assign w_streak_inc = (r_state == ST_IDLE) ? SW'(1) : r_streak + SW'(1);

  // Next-state, streak and predecessor logic; only valid samples advance.
  always_comb begin
    w_state_nxt  = r_state;
    w_streak_nxt = r_streak;
    w_prev_nxt   = r_prev;
    w_lock_lost  = 1'b0;
    if (in_valid) begin
      // A guard upset advances prev so the following sample is not flagged.
      if (r_state == ST_IDLE)  w_prev_nxt = in_value;
      else if (w_guard_bad)    w_prev_nxt = r_prev + width'(1);
      else                     w_prev_nxt = in_value;
      case (r_state)
        ST_IDLE, ST_ACQUIRE: begin
          if (w_bad) begin
            w_state_nxt  = ST_ACQUIRE;
            w_streak_nxt = '0;
          end else begin
            w_streak_nxt = w_streak_inc;
            w_state_nxt  = (w_streak_inc == LOCK_N) ? ST_LOCKED : ST_ACQUIRE;
          end
        end
        ST_LOCKED: begin
          if (w_bad) begin
            w_state_nxt  = ST_ACQUIRE;
            w_streak_nxt = '0;
            w_lock_lost  = 1'b1;
          end
        end
        default: begin
          w_state_nxt  = ST_IDLE;
          w_streak_nxt = '0;
        end
      endcase
    end
  end

  // clear_err is applied first, then the current sample's contribution.
  always_comb begin
    w_err_base  = clear_err ? '0 : r_err_count;
    w_err_nxt   = w_err_base;
    if (in_valid && w_bad && (w_err_base != '1))
      w_err_nxt = w_err_base + err_width'(1);
    w_fault_nxt = (clear_err ? 1'b0 : r_fault) | w_lock_lost;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_streak    <= '0;
      r_prev      <= '0;
      r_locked    <= 1'b0;
      r_fault     <= 1'b0;
      r_guard_err <= 1'b0;
      r_seq_err   <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_streak    <= w_streak_nxt;
      r_prev      <= w_prev_nxt;
      r_locked    <= (w_state_nxt == ST_LOCKED);
      r_fault     <= w_fault_nxt;
      r_guard_err <= in_valid && w_guard_bad;
      r_seq_err   <= in_valid && w_seq_bad;
      r_err_count <= w_err_nxt;
    end
  end

  assign locked    = r_locked;
  assign fault     = r_fault;
  assign guard_err = r_guard_err;
  assign seq_err   = r_seq_err;
  assign err_count = r_err_count;
  assign state     = r_state;

endmodule

// File: tb/tb_guarded_counter_checker.sv
// Bench for guarded_counter_checker: a default instance (lock_count=4,
// err_width=8) and a second one (lock_count=1, err_width=2) share stimulus.
module tb_guarded_counter_checker;

  localparam int EW = 22;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_value = '0;
  logic [3:0] in_even = '0;
  logic [3:0] in_odd = '0;
  logic       clear_err = 1'b0;

  logic       locked, fault, guard_err, seq_err;
  logic [7:0] err_count;
  logic [1:0] state;
  logic       locked_s, fault_s, guard_err_s, seq_err_s;
  logic [1:0] err_count_s;
  logic [1:0] state_s;

  int n_tests = 0;
  int n_fail  = 0;
  logic [EW-1:0] exp_q[$];

  // model state, index 0 = default instance, 1 = small instance
  int m_state[2], m_streak[2], m_prev[2], m_err[2];
  bit m_fault[2], m_g[2], m_s[2];

  // clock / reset
  always #5 clk = ~clk;

  guarded_counter_checker dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_value(in_value),
    .in_even(in_even), .in_odd(in_odd), .clear_err(clear_err),
    .locked(locked), .fault(fault), .guard_err(guard_err), .seq_err(seq_err),
    .err_count(err_count), .state(state));

  guarded_counter_checker #(.width(8), .guard_bits(4), .lock_count(1), .err_width(2)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_value(in_value),
    .in_even(in_even), .in_odd(in_odd), .clear_err(clear_err),
    .locked(locked_s), .fault(fault_s), .guard_err(guard_err_s), .seq_err(seq_err_s),
    .err_count(err_count_s), .state(state_s));

  function automatic logic [3:0] gev(input logic [7:0] v);
    return 4'($countones(v & 8'h55));
  endfunction

  function automatic logic [3:0] god(input logic [7:0] v);
    return 4'($countones(v & 8'hAA));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference behaviour, one step per driven cycle
  task automatic model_step(input bit r, input bit v, input logic [7:0] val,
                            input logic [3:0] ev, input logic [3:0] od, input bit clr);
    for (int k = 0; k < 2; k++) begin
      int lc, emax;
      bit bad;
      lc   = (k == 0) ? 4 : 1;
      emax = (k == 0) ? 255 : 3;
      if (r) begin
        m_state[k] = 0; m_streak[k] = 0; m_prev[k] = 0; m_err[k] = 0;
        m_fault[k] = 0; m_g[k] = 0; m_s[k] = 0;
      end else begin
        m_g[k] = 0; m_s[k] = 0;
        if (clr) begin m_err[k] = 0; m_fault[k] = 0; end
        if (v) begin
          m_g[k] = (ev != gev(val)) || (od != god(val));
          m_s[k] = (m_state[k] != 0) && !m_g[k] && (val != 8'((m_prev[k] + 1) % 256));
          bad = m_g[k] || m_s[k];
          if (m_state[k] == 0 || !m_g[k]) m_prev[k] = val;
          else m_prev[k] = (m_prev[k] + 1) % 256;
          if (m_state[k] == 2) begin
            if (bad) begin m_state[k] = 1; m_streak[k] = 0; m_fault[k] = 1; end
          end else if (bad) begin
            m_state[k] = 1; m_streak[k] = 0;
          end else begin
            m_streak[k] = (m_state[k] == 0) ? 1 : m_streak[k] + 1;
            m_state[k]  = (m_streak[k] >= lc) ? 2 : 1;
          end
          if (bad && m_err[k] < emax) m_err[k]++;
        end
      end
    end
  endtask

  function automatic logic [EW-1:0] pack_exp();
    return {m_state[0] == 2, m_fault[0], m_g[0], m_s[0], 2'(m_state[0]), 8'(m_err[0]),
            m_state[1] == 2, m_fault[1], m_g[1], m_s[1], 2'(m_state[1]), 2'(m_err[1])};
  endfunction

  // scoreboard: compare DUT outputs with the oldest pending expectation
  task automatic check_out();
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("locked",      locked,      e[21]);
      check("fault",       fault,       e[20]);
      check("guard_err",   guard_err,   e[19]);
      check("seq_err",     seq_err,     e[18]);
      check("state",       state,       e[17:16]);
      check("err_count",   err_count,   e[15:8]);
      check("locked_s",    locked_s,    e[7]);
      check("fault_s",     fault_s,     e[6]);
      check("guard_err_s", guard_err_s, e[5]);
      check("seq_err_s",   seq_err_s,   e[4]);
      check("state_s",     state_s,     e[3:2]);
      check("err_count_s", err_count_s, e[1:0]);
    end
  endtask

  // driver: one cycle of stimulus, driven on the falling edge
  task automatic cycle(input bit r, input bit v, input logic [7:0] val,
                       input logic [3:0] ev, input logic [3:0] od, input bit clr);
    @(negedge clk);
    check_out();
    rst = r; in_valid = v; in_value = val; in_even = ev; in_odd = od; clear_err = clr;
    model_step(r, v, val, ev, od, clr);
    exp_q.push_back(pack_exp());
  endtask

  task automatic send(input logic [7:0] v);
    cycle(1'b0, 1'b1, v, gev(v), god(v), 1'b0);
  endtask

  task automatic send_gappy(input logic [7:0] v);
    if ($urandom_range(0, 4) == 0) cycle(1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0);
    send(v);
  endtask

  // idle cycle; afterwards the outputs show the result of the previous sample
  task automatic settle();
    cycle(1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0);
  endtask

  initial begin
    logic [7:0] nxt;
    int r;
    cycle(1'b1, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0);
    settle();
    check("reset_state", state, 2'd0);
    check("reset_err", err_count, 8'd0);

    // lock acquisition
    send(8'h00);
    settle();
    check("acq_state", state, 2'd1);
    check("acq_locked_s", locked_s, 1'b1);
    send(8'h01); send(8'h02);
    settle();
    check("acq_not_locked", locked, 1'b0);
    send(8'h03);
    settle();
    check("acq_locked", locked, 1'b1);
    for (int i = 4; i < 256; i++) send_gappy(8'(i));
    send(8'h00); send(8'h01);
    settle();
    check("wrap_locked", locked, 1'b1);
    check("wrap_err", err_count, 8'd0);

    // single upset: 0x15 corrupted to 0x17, guards still those of 0x15
    for (int i = 2; i <= 8'h14; i++) send_gappy(8'(i));
    cycle(1'b0, 1'b1, 8'h17, 4'd3, 4'd0, 1'b0);
    settle();
    check("upset_guard", guard_err, 1'b1);
    check("upset_seq", seq_err, 1'b0);
    check("upset_err", err_count, 8'd1);
    check("upset_fault", fault, 1'b1);
    check("upset_locked", locked, 1'b0);
    send(8'h16); send(8'h17); send(8'h18);
    settle();
    check("relock_early", locked, 1'b0);
    send(8'h19);
    settle();
    check("relock", locked, 1'b1);

    // skip
    for (int i = 8'h1A; i <= 8'h20; i++) send_gappy(8'(i));
    send(8'h22);
    settle();
    check("skip_seq", seq_err, 1'b1);
    check("skip_guard", guard_err, 1'b0);
    send(8'h23);
    settle();
    check("skip_resync", seq_err, 1'b0);
    check("skip_err", err_count, 8'd2);

    // saturation and clear
    for (int i = 8'h24; i <= 8'h28; i++)
      cycle(1'b0, 1'b1, 8'(i), gev(8'(i)) + 4'd1, god(8'(i)), 1'b0);
    settle();
    check("sat_small", err_count_s, 2'd3);
    check("sat_big", err_count, 8'd7);
    cycle(1'b0, 1'b1, 8'h29, gev(8'h29), god(8'h29) + 4'd1, 1'b1);
    settle();
    check("clear_bad_small", err_count_s, 2'd1);
    check("clear_bad_big", err_count, 8'd1);
    cycle(1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 1'b1);
    settle();
    check("clear_only", err_count, 8'd0);

    // lock, lose it, relock with fault set, then reset
    for (int i = 8'h2A; i <= 8'h2D; i++) send(8'(i));
    cycle(1'b0, 1'b1, 8'h2E, gev(8'h2E) + 4'd2, god(8'h2E), 1'b0);
    for (int i = 8'h2F; i <= 8'h32; i++) send(8'(i));
    settle();
    check("pre_rst_locked", locked, 1'b1);
    check("pre_rst_fault", fault, 1'b1);
    cycle(1'b1, 1'b1, 8'h33, gev(8'h33), god(8'h33), 1'b1);
    settle();
    check("rst_locked", locked, 1'b0);
    check("rst_fault", fault, 1'b0);
    check("rst_err", err_count, 8'd0);
    check("rst_state", state, 2'd0);
    send(8'h40);
    settle();
    check("post_rst_state", state, 2'd1);
    check("post_rst_seq", seq_err, 1'b0);

    // random mix
    nxt = 8'h41;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 29);
      if (r == 0) settle();
      else if (r == 1) begin
        cycle(1'b0, 1'b1, nxt, gev(nxt) ^ 4'(1 << $urandom_range(0, 3)), god(nxt), 1'b0);
        nxt = nxt + 8'd1;
      end else if (r == 2) begin
        nxt = nxt + 8'(1 + $urandom_range(1, 3));
        send(nxt);
        nxt = nxt + 8'd1;
      end else if (r == 3) begin
        cycle(1'b0, 1'b1, nxt, gev(nxt), god(nxt), 1'b1);
        nxt = nxt + 8'd1;
      end else if (r == 4) begin
        cycle(1'b1, 1'b0, 8'h00, 4'h0, 4'h0, 1'b0);
        nxt = 8'($urandom_range(0, 255));
      end else begin
        send(nxt);
        nxt = nxt + 8'd1;
      end
    end
    settle();
    @(negedge clk);
    check_out();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
